// File: rtl/button_press_decoder.sv
// Short/long/auto-repeat button press decoder with a post-reset lockout.
// Define BUTTON_AUTOREPEAT_EN to compile in the repeat_press pulses.
module button_press_decoder #(
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 250000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_in,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic held
);

    localparam int MAX_CYCLES =
        (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        LOCKOUT,
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          short_d;
    logic          long_d;
    logic          rep_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= LOCKOUT;
            cnt_q        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            short_press  <= short_d;
            long_press   <= long_d;
            repeat_press <= rep_d;
            held         <= (state_d == PRESSED) || (state_d == LONG);
        end
    end

    // Counter is compared before incrementing, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            LOCKOUT: begin
                if (!btn_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (btn_in) begin
                    state_d = PRESSED;
                    cnt_d   = CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_in) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!btn_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        rep_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            default: begin
                state_d = LOCKOUT;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: press-count model plus directed scenarios.
// Follows BUTTON_AUTOREPEAT_EN to pick the expected repeat behaviour.
module tb_button_press_decoder;

    localparam int L = 8;
    localparam int R = 4;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic btn_in = 1'b0;
    logic short_press;
    logic long_press;
    logic repeat_press;
    logic held;

    button_press_decoder #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .btn_in      (btn_in),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    // Model: count consecutive pressed samples since the press began.
    bit lock = 1'b1;
    int n = 0;
    bit e_short = 1'b0;
    bit e_long = 1'b0;
    bit e_rep = 1'b0;
    bit e_held = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock = 1'b1;
            n = 0;
            e_short = 1'b0;
            e_long = 1'b0;
            e_rep = 1'b0;
            e_held = 1'b0;
        end else begin
            e_short = 1'b0;
            e_long = 1'b0;
            e_rep = 1'b0;
            if (lock) begin
                e_held = 1'b0;
                if (!btn_in) lock = 1'b0;
            end else if (btn_in) begin
                n = n + 1;
                e_long = (n == L);
                e_rep = AR && (n > L) && ((n - L) % R == 0);
                e_held = 1'b1;
            end else begin
                e_short = (n > 0) && (n < L);
                n = 0;
                e_held = 1'b0;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int s_cnt = 0;
    int l_cnt = 0;
    int r_cnt = 0;
    int r_sum = 0;
    int h_cnt = 0;
    int long_at = 0;

    task automatic expect_eq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] got;
        logic [3:0] want;
        @(negedge clk);
        got  = {short_press, long_press, repeat_press, held};
        want = {e_short, e_long, e_rep, e_held};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got s/l/r/h=%b want %b",
                     $time, got, want);
        end
        if (short_press) s_cnt++;
        if (long_press) begin
            l_cnt++;
            long_at = n;
        end
        if (repeat_press) begin
            r_cnt++;
            r_sum += n;
        end
        if (held) h_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int cycles);
        btn_in = v;
        repeat (cycles) tick();
    endtask

    task automatic run_press(input string name, input int len,
                             input int x_s, input int x_l, input int x_at,
                             input int x_r, input int x_rsum, input int x_h);
        int s0, l0, r0, rs0, h0;
        s0 = s_cnt; l0 = l_cnt; r0 = r_cnt; rs0 = r_sum; h0 = h_cnt;
        long_at = 0;
        hold(1'b1, len);
        hold(1'b0, 3);
        expect_eq({name, "_short"}, s_cnt - s0, x_s);
        expect_eq({name, "_long"}, l_cnt - l0, x_l);
        expect_eq({name, "_long_at"}, long_at, x_at);
        expect_eq({name, "_rep"}, r_cnt - r0, x_r);
        expect_eq({name, "_rep_pos_sum"}, r_sum - rs0, x_rsum);
        expect_eq({name, "_held"}, h_cnt - h0, x_h);
    endtask

    initial begin
        int s0, l0, r0, h0;
        rstn = 1'b0;
        btn_in = 1'b0;
        tick();
        tick();
        expect_eq("reset_outs",
                  int'({short_press, long_press, repeat_press, held}), 0);
        rstn = 1'b1;
        hold(1'b0, 2);

        run_press("p3", 3, 1, 0, 0, 0, 0, 3);
        run_press("p7", 7, 1, 0, 0, 0, 0, 7);
        run_press("p8", 8, 0, 1, 8, 0, 0, 8);
        run_press("p21", 21, 0, 1, 8, AR ? 3 : 0, AR ? 48 : 0, 21);

        // Button held through reset release stays silent.
        rstn = 1'b0;
        btn_in = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        s0 = s_cnt; l0 = l_cnt; r0 = r_cnt; h0 = h_cnt;
        hold(1'b1, 10);
        expect_eq("lock_pulses",
                  (s_cnt - s0) + (l_cnt - l0) + (r_cnt - r0), 0);
        expect_eq("lock_held", h_cnt - h0, 0);
        hold(1'b0, 2);
        run_press("after_lock", 3, 1, 0, 0, 0, 0, 3);

        // Reset in the middle of a press aborts it.
        s0 = s_cnt; l0 = l_cnt;
        hold(1'b1, 5);
        expect_eq("mid_held_before", int'(held), 1);
        rstn = 1'b0;
        #1;
        expect_eq("mid_reset_outs",
                  int'({short_press, long_press, repeat_press, held}), 0);
        btn_in = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        hold(1'b0, 4);
        expect_eq("mid_short", s_cnt - s0, 0);
        expect_eq("mid_long", l_cnt - l0, 0);
        run_press("after_mid", 2, 1, 0, 0, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_press_decoder.md
BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 1000000, consecutive pressed samples that qualify a long press; legal range 2 or more.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 250000, pressed samples between auto-repeat pulses after a long press; legal range 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port btn_in, input, 1 bit: debounced button level, high = pressed, already synchronous to clk.
REQ-006 SHALL have port short_press, output, 1 bit: one-cycle pulse for a press released before qualifying as long.
REQ-007 SHALL have port long_press, output, 1 bit: one-cycle pulse when a press qualifies as long.
REQ-008 SHALL have port repeat_press, output, 1 bit: one-cycle pulse per auto-repeat interval while a long press is held.
REQ-009 SHALL have port held, output, 1 bit: level, high while the FSM is in PRESSED or LONG.

Function
REQ-010 SHALL drive all outputs from registers; no combinational path from btn_in to any output.
REQ-011 SHALL implement FSM states LOCKOUT, IDLE, PRESSED and LONG, plus one counter sized to hold max(LONG_CYCLES, REPEAT_CYCLES).
REQ-012 LOCKOUT: btn_in sampled low goes to IDLE; btn_in sampled high stays in LOCKOUT; no pulses.
REQ-013 IDLE: btn_in sampled high goes to PRESSED with counter=1; this edge counts as pressed sample 1.
REQ-014 PRESSED, btn_in high, counter below LONG_CYCLES-1: stay in PRESSED and increment the counter.
REQ-015 PRESSED, btn_in high, counter=LONG_CYCLES-1 (the LONG_CYCLES-th sample): assert long_press for the next cycle, go to LONG, counter=0.
REQ-016 PRESSED, btn_in sampled low: assert short_press for the next cycle and go to IDLE.
REQ-017 LONG, btn_in sampled low: go to IDLE; no short_press, long_press or repeat_press is emitted on release.
REQ-018 Auto-repeat in LONG, btn_in high: if counter=REPEAT_CYCLES-1, assert repeat_press for the next cycle and set counter=0; otherwise increment the counter.
REQ-019 Repeat pulses therefore follow pressed samples LONG_CYCLES+k*REPEAT_CYCLES, for k=1,2,...
REQ-020 At most one of short_press, long_press and repeat_press SHALL be high in any cycle; each pulse SHALL be exactly one cycle wide.
REQ-021 The counter SHALL never wrap: it is reset on each state entry and compared before incrementing.
REQ-022 held SHALL rise in the cycle after the IDLE-to-PRESSED edge and fall in the cycle after the release edge.

Reset
REQ-023 While rstn is low, state SHALL be LOCKOUT, counter=0, and short_press, long_press, repeat_press and held all 0.
REQ-024 Reset asserted mid-press SHALL abort the press with no pulse, then or later.
REQ-025 A button held through reset release SHALL produce no events until btn_in is first sampled low.

Configuration
REQ-026 Macro BUTTON_AUTOREPEAT_EN defined: the auto-repeat behaviour of REQ-018 and REQ-019 is compiled in.
REQ-027 Macro BUTTON_AUTOREPEAT_EN undefined: repeat_press is tied to 0, the counter holds in LONG, and all other behaviour is unchanged.

Verification
REQ-028 LONG_CYCLES=8: high for 3 samples then low -> one short_press pulse after the release edge; long_press stays 0; held high for 3 cycles.
REQ-029 LONG_CYCLES=8: high for 7 samples then low -> short_press only. High for 8 samples then low -> long_press after the 8th sample, no short_press.
REQ-030 LONG_CYCLES=8, REPEAT_CYCLES=4, macro defined, high for 21 samples -> long_press after sample 8; repeat_press after samples 12, 16 and 20; nothing on release.
REQ-031 Same stimulus as REQ-030 with the macro undefined -> long_press after sample 8 only; repeat_press never asserts.
REQ-032 rstn released while btn_in is high for 10 samples -> no pulses and held=0; then low, then high 3 samples -> one short_press.
REQ-033 rstn asserted at pressed sample 5 and released with btn_in low -> all outputs 0 immediately; no short_press afterwards.
